// File: rtl/pattern_stream_buffer_pkg.sv
// Shared definitions for pattern_stream_buffer: pattern mode encodings, reader
// FSM states and the LFSR seed/taps used by the generator.
package pattern_stream_buffer_pkg;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_INV   = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_PAUSE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_READY = 2'd3
    } rd_state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Taps 8,6,5,4 expressed as a mask over bits [7:0].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pattern_stream_buffer_pattern_gen.sv
// pattern_gen: sequence counter, LFSR and per-lane word formation; advances one
// step on every non-paused sample event.
module pattern_gen
    import pattern_stream_buffer_pkg::*;
#(
    parameter int LANES = 3
) (
    input  logic               ref_clk,
    input  logic               rst,
    input  logic               step,
    input  mode_e              mode,
    output logic [8*LANES-1:0] word
);
    logic [7:0] seq_q, seq_d;
    logic [7:0] lfsr_q, lfsr_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        seq_d  = seq_q;
        lfsr_d = lfsr_q;
        if (step) begin
            seq_d  = seq_q + 8'd1;
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < LANES; k++) begin
            case (mode)
                MODE_CNT:  word[8*k +: 8] = seq_q + 8'(k);
                MODE_INV:  word[8*k +: 8] = ~(seq_q + 8'(k));
                MODE_LFSR: word[8*k +: 8] = lfsr_q ^ 8'(k);
                default:   word[8*k +: 8] = 8'h00;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            seq_q  <= 8'h00;
            lfsr_q <= LFSR_SEED;
        end else begin
            seq_q  <= seq_d;
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/pattern_stream_buffer.sv
// pattern_stream_buffer: pattern generator writing a circular buffer drained by a
// four-phase reader. Define REQ_SYNC_EN to pass data_req through a two-flop synchroniser.
module pattern_stream_buffer
    import pattern_stream_buffer_pkg::*;
#(
    parameter int LANES        = 3,
    parameter int ADDR_W       = 9,
    parameter int WRITE_PERIOD = 7
) (
    input  logic               ref_clk,
    input  logic               rst,
    input  logic               gen_en,
    input  logic [1:0]         pattern_mode,
    input  logic               ovf_clr,
    input  logic               data_req,
    output logic               data_rdy,
    output logic [8*LANES-1:0] data_out,
    output logic [ADDR_W:0]    fill_level,
    output logic               overflow
);
    localparam int W      = 8 * LANES;
    localparam int D      = 1 << ADDR_W;
    localparam int TICK_W = $clog2(WRITE_PERIOD);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WRITE_PERIOD - 1);
    localparam logic [ADDR_W:0]   FILL_MAX  = (ADDR_W+1)'(D);

    logic              req_s;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              ovf_q, ovf_d;
    rd_state_e         state_q, state_d;
    logic              data_rdy_q, data_rdy_d;
    logic [W-1:0]      data_out_q, data_out_d;
    logic [W-1:0]      gen_word, ram_rdata;
    logic              sample, gen_step, wr_en, drop, rd_en, commit;

`ifdef REQ_SYNC_EN
    logic [1:0] req_sync_q;
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) req_sync_q <= 2'b00;
        else      req_sync_q <= {req_sync_q[0], data_req};
    end
    assign req_s = req_sync_q[1];
`else
    assign req_s = data_req;
`endif

    pattern_gen #(.LANES(LANES)) u_gen (
        .ref_clk (ref_clk),
        .rst     (rst),
        .step    (gen_step),
        .mode    (mode_e'(pattern_mode)),
        .word    (gen_word)
    );

    always_comb begin
        sample   = gen_en && (tick_q == TICK_LAST);
        gen_step = sample && (mode_e'(pattern_mode) != MODE_PAUSE);
        wr_en    = gen_step && (fill_q != FILL_MAX);
        drop     = gen_step && (fill_q == FILL_MAX);
        rd_en    = (state_q == ST_FETCH);
        commit   = (state_q == ST_READY) && !req_s;

        tick_d = tick_q;
        if (gen_en) tick_d = sample ? '0 : tick_q + TICK_W'(1);

        wr_ptr_d = wr_en  ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = commit ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        fill_d = fill_q;
        if (wr_en && !commit)      fill_d = fill_q + (ADDR_W+1)'(1);
        else if (commit && !wr_en) fill_d = fill_q - (ADDR_W+1)'(1);

        // A drop in the same cycle as ovf_clr keeps the flag set.
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_comb begin
        state_d    = state_q;
        data_rdy_d = data_rdy_q;
        data_out_d = data_out_q;
        case (state_q)
            ST_IDLE:  if (req_s && fill_q != '0) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                data_out_d = ram_rdata;
                data_rdy_d = 1'b1;
                state_d    = ST_READY;
            end
            ST_READY: if (!req_s) begin
                data_rdy_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: buffer storage has no reset; fill_level keeps the reader off unwritten words.
    generate
        if (ADDR_W == 9) begin : g_lane_mem
            // One 512x8 array per lane so each maps onto a single 512x8 block RAM.
            for (genvar k = 0; k < LANES; k++) begin : g_lane
                logic [7:0] mem [D];
                logic [7:0] rdata_q;
                always_ff @(posedge ref_clk) begin
                    if (wr_en) mem[wr_ptr_q] <= gen_word[8*k +: 8];
                    if (rd_en) rdata_q <= mem[rd_ptr_q];
                end
                assign ram_rdata[8*k +: 8] = rdata_q;
            end
        end else begin : g_wide_mem
            logic [W-1:0] mem [D];
            logic [W-1:0] rdata_q;
            always_ff @(posedge ref_clk) begin
                if (wr_en) mem[wr_ptr_q] <= gen_word;
                if (rd_en) rdata_q <= mem[rd_ptr_q];
            end
            assign ram_rdata = rdata_q;
        end
    endgenerate

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            tick_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
            data_rdy_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            tick_q     <= tick_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            data_rdy_q <= data_rdy_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_rdy   = data_rdy_q;
    assign data_out   = data_out_q;
    assign fill_level = fill_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pattern_stream_buffer.sv
// Scoreboard bench for pattern_stream_buffer: a queue-based reference model predicts
// buffered words, fill level and overflow; a monitor compares on every data_rdy rise.
module tb_pattern_stream_buffer;
    localparam int LANES = 3;
    localparam int ADDR_W = 4;
    localparam int WP = 7;
    localparam int W = 8 * LANES;
    localparam int D = 1 << ADDR_W;
`ifdef REQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = 3 + SYNC;

    logic              ref_clk = 1'b0;
    logic              rst = 1'b0;
    logic              gen_en = 1'b0;
    logic [1:0]        pattern_mode = 2'd0;
    logic              ovf_clr = 1'b0;
    logic              data_req = 1'b0;
    logic              data_rdy;
    logic [W-1:0]      data_out;
    logic [ADDR_W:0]   fill_level;
    logic              overflow;

    pattern_stream_buffer #(.LANES(LANES), .ADDR_W(ADDR_W), .WRITE_PERIOD(WP)) dut (
        .ref_clk      (ref_clk),
        .rst          (rst),
        .gen_en       (gen_en),
        .pattern_mode (pattern_mode),
        .ovf_clr      (ovf_clr),
        .data_req     (data_req),
        .data_rdy     (data_rdy),
        .data_out     (data_out),
        .fill_level   (fill_level),
        .overflow     (overflow)
    );

    always #5 ref_clk = ~ref_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int           m_fill = 0;
    int           m_tick = 0;
    bit           m_ovf = 0;
    logic [7:0]   m_seq = 8'h00;
    logic [7:0]   m_lfsr = 8'h01;
    int           m_commit_cnt = 0;
    int           rel_stamp = 0;
    int           rel_seen = 0;
    bit           m_fire, m_commit, m_wr, m_drop;

    function automatic logic [W-1:0] model_word(input logic [1:0] mode, input logic [7:0] s,
                                                input logic [7:0] l);
        logic [W-1:0] w = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [7:0] v;
            case (mode)
                2'd0:    v = s + 8'(k);
                2'd1:    v = ~(s + 8'(k));
                default: v = l ^ 8'(k);
            endcase
            w[8*k +: 8] = v;
        end
        return w;
    endfunction

    always @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_fill = 0; m_tick = 0; m_ovf = 0;
            m_seq = 8'h00; m_lfsr = 8'h01;
            m_commit_cnt = 0; rel_seen = rel_stamp;
        end else begin
            // Release seen at F1 commits SYNC edges later.
            if (rel_stamp != rel_seen) begin
                rel_seen = rel_stamp;
                m_commit_cnt = 1 + SYNC;
            end
            m_commit = 0;
            if (m_commit_cnt > 0) begin
                m_commit_cnt--;
                m_commit = (m_commit_cnt == 0);
            end
            m_fire = gen_en && (m_tick == WP - 1) && (pattern_mode != 2'd3);
            if (gen_en) m_tick = (m_tick + 1) % WP;
            m_wr   = m_fire && (m_fill < D);
            m_drop = m_fire && (m_fill == D);
            if (m_wr) exp_q.push_back(model_word(pattern_mode, m_seq, m_lfsr));
            if (m_fire) begin
                m_seq  = m_seq + 8'd1;
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            end
            if (m_drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_fill = m_fill + (m_wr ? 1 : 0) - (m_commit ? 1 : 0);
        end
    end

    // ---------------- monitor ----------------
    bit           prev_rdy = 0;
    logic [W-1:0] held = '0;

    always @(negedge ref_clk) begin
        if (!rst) begin
            prev_rdy = 0;
            held = '0;
        end else begin
            check("fill_level", 32'(fill_level), 32'(m_fill));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (data_rdy && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_word: data_out=%h presented with nothing buffered", data_out);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check("data_out", 32'(data_out), 32'(held));
            prev_rdy = data_rdy;
        end
    end

    // ---------------- driver ----------------
    logic [W-1:0] rd_word;
    int           wait_n;

    task automatic do_reset(input logic [1:0] mode, input bit en);
        @(negedge ref_clk); #1;
        rst = 0; data_req = 0; ovf_clr = 0; gen_en = 0; pattern_mode = mode;
        @(negedge ref_clk); #1;
        rst = 1; gen_en = en;
    endtask

    task automatic do_read(input bit chk_lat, output logic [W-1:0] word);
        int  n = 0;
        bit  seen = 0;
        bit  lat_ok;
        @(negedge ref_clk);
        data_req = 1;
        lat_ok = chk_lat && (m_fill > 0);
        while (!seen && n < 400) begin
            @(negedge ref_clk);
            n++;
            if (data_rdy) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rdy_timeout: data_rdy low after %0d cycles, expected a word", n);
            data_req = 0;
            word = '0;
        end else begin
            if (lat_ok) check("rdy_latency", 32'(n), 32'(LAT));
            word = data_out;
            data_req = 0;
            rel_stamp++;
            n = 0;
            while (data_rdy && n < 20) begin
                @(negedge ref_clk);
                n++;
            end
            check("release_latency", 32'(n), 32'(1 + SYNC));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held low.
        repeat (2) @(negedge ref_clk);
        #1;
        check("rst_data_rdy", 32'(data_rdy), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_fill", 32'(fill_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1; gen_en = 1; pattern_mode = 2'd0;

        // Fill to full, overflow, clear, and drop-beats-clear.
        repeat (112) @(posedge ref_clk);
        @(negedge ref_clk);
        check("fill_at_sample16", 32'(fill_level), 16);
        check("ovf_before_drop", 32'(overflow), 0);
        repeat (7) @(negedge ref_clk);
        check("ovf_after_drop", 32'(overflow), 1);
        check("fill_stays_full", 32'(fill_level), 16);
        ovf_clr = 1;
        @(negedge ref_clk);
        check("ovf_cleared", 32'(overflow), 0);
        repeat (6) @(negedge ref_clk);
        check("drop_beats_clear", 32'(overflow), 1);
        ovf_clr = 0;
        // Drain past the pointer wrap while writes continue.
        for (int i = 0; i < 24; i++) do_read(1, rd_word);

        // Mode 0 first words.
        do_reset(2'd0, 1);
        repeat (30) @(negedge ref_clk);
        do_read(1, rd_word); check("mode0_word0", 32'(rd_word), 32'h020100);
        do_read(1, rd_word); check("mode0_word1", 32'(rd_word), 32'h030201);
        do_read(1, rd_word); check("mode0_word2", 32'(rd_word), 32'h040302);

        do_reset(2'd1, 1);
        repeat (10) @(negedge ref_clk);
        do_read(1, rd_word); check("mode1_word0", 32'(rd_word), 32'hFDFEFF);

        do_reset(2'd2, 1);
        repeat (10) @(negedge ref_clk);
        do_read(1, rd_word); check("mode2_word0", 32'(rd_word), 32'h030001);

        // Pause: ticks run, nothing written, seq holds.
        do_reset(2'd3, 1);
        repeat (50) @(negedge ref_clk);
        check("pause_fill", 32'(fill_level), 0);
        pattern_mode = 2'd0;
        repeat (10) @(negedge ref_clk);
        do_read(1, rd_word); check("after_pause_word", 32'(rd_word), 32'h020100);

        // Request while empty: data_rdy waits for the first write.
        do_reset(2'd0, 0);
        fork
            do_read(0, rd_word);
            begin
                repeat (20) @(negedge ref_clk);
                check("rdy_low_while_empty", 32'(data_rdy), 0);
                gen_en = 1;
            end
        join
        check("first_word_after_empty", 32'(rd_word), 32'h020100);

        // Randomized modes, enables, clears and handshake gaps.
        do_reset(2'd0, 1);
        for (int i = 0; i < 150; i++) begin
            @(negedge ref_clk);
            pattern_mode = 2'($urandom_range(0, 3));
            gen_en = ($urandom_range(0, 7) != 0);
            ovf_clr = ($urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 20)) @(negedge ref_clk);
            ovf_clr = 0;
            if (m_fill == 0) begin
                gen_en = 1;
                pattern_mode = 2'd0;
            end
            do_read(1, rd_word);
        end

        // Reset asserted while a word is presented.
        do_reset(2'd0, 1);
        repeat (30) @(negedge ref_clk);
        data_req = 1;
        wait_n = 0;
        while (!data_rdy && wait_n < 50) begin
            @(negedge ref_clk);
            wait_n++;
        end
        check("ready_before_reset", 32'(data_rdy), 1);
        @(posedge ref_clk);
        #2;
        rst = 0; data_req = 0;
        #1;
        check("async_rst_data_rdy", 32'(data_rdy), 0);
        check("async_rst_data_out", 32'(data_out), 0);
        check("async_rst_fill", 32'(fill_level), 0);
        check("async_rst_overflow", 32'(overflow), 0);
        @(negedge ref_clk); #1;
        rst = 1;
        repeat (10) @(negedge ref_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_stream_buffer.md
# pattern_stream_buffer

Parametrised test-pattern source and streaming buffer for the Raspberry Pi GPIO parallel link. A pattern generator writes multi-lane samples at a fixed cadence into a circular on-chip buffer. A four-phase reader hands them, one word per handshake, to the downstream parallel port. It replaces the fixed 3-lane, free-running-write test block and adds:
- selectable patterns
- full/empty tracking
- overflow detection
- a fill-level output

## Interface
Parameters:
- LANES, 3, number of 8-bit lanes per word (1..4); word width W = 8*LANES
- ADDR_W, 9, buffer address width; depth D = 2^ADDR_W
- WRITE_PERIOD, 7, clock cycles between generated samples (>= 2)

Ports:
- ref_clk  in  1  sole clock, 12 MHz iCEstick oscillator
- rst  in  1  asynchronous, active-low reset
- gen_en  in  1  generator enable; when low the tick counter holds
- pattern_mode  in  2  0 counter, 1 inverted counter, 2 LFSR, 3 pause (ticks run, no writes)
- ovf_clr  in  1  synchronous clear of overflow
- data_req  in  1  downstream request (four-phase)
- data_rdy  out  1  word valid on data_out
- data_out  out  W  lane k at bits [8k+7:8k]
- fill_level  out  ADDR_W+1  words currently buffered (0..D)
- overflow  out  1  sticky: a sample was dropped because the buffer was full

## Operation
- **Reset (rst low):** all state clears immediately, independent of ref_clk.
  - data_rdy=0, data_out=0, fill_level=0, overflow=0
  - write and read pointers = 0, seq=0, LFSR=8'h01, tick counter=0
  - reader FSM in IDLE
- **Tick:** counter runs 0..WRITE_PERIOD-1 while gen_en=1. A sample event occurs in the cycle where it equals WRITE_PERIOD-1.
- **Sample event, mode 3:** nothing is written and seq/LFSR hold.
- **Sample event, modes 0-2:**
  - lane k of the generated word: mode 0 = seq+k (mod 256); mode 1 = ~(seq+k); mode 2 = lfsr ^ k
  - if fill_level < D: word written at the write pointer; write pointer increments, wrapping D-1 -> 0
  - if fill_level = D: word dropped, overflow set to 1
  - in both cases seq increments and the LFSR steps, so drops are visible as gaps in the data
- **LFSR:** 8-bit Fibonacci, taps 8,6,5,4, shifts left, feedback into bit 0, seed 8'h01.
- **pattern_mode changes** take effect at the next sample event.
- **overflow:** cleared by ovf_clr=1 unless a drop occurs in the same cycle; a drop wins.
- **fill_level:** +1 on write, -1 on read commit, unchanged when both occur in the same cycle. It never wraps.
- **Reader FSM:**
  - IDLE: req_s=1 and fill_level>0 -> FETCH. With fill_level=0 it waits in IDLE; no underflow is possible.
  - FETCH: RAM read enable high for one cycle at the read pointer -> LATCH.
  - LATCH: RAM output captured into data_out, data_rdy set to 1 -> READY.
  - READY: data_out holds stable. On req_s=0: data_rdy=0, read pointer +1 (wrapping), fill_level decrements (read commit) -> IDLE.
- **data_out** keeps the last word after data_rdy falls.

## Timing
- RAM has a registered read: address and enable are sampled at edge n, data is valid after edge n.
- Edge numbering: E1 is the first ref_clk edge at which data_req=1 is sampled.
  - req_s = data_req delayed by the synchroniser, or data_req directly (see Configuration).
  - With REQ_SYNC_EN: data_rdy rises after E5.
  - Without REQ_SYNC_EN: data_rdy rises after E3.
- Release: with F1 the first edge sampling data_req=0, data_rdy falls after F3 with the synchroniser and after F1 without it.
- Sustained throughput is bounded by the handshake, not the buffer. Writes never stall the reader.
- Reset asserted mid-handshake drops data_rdy asynchronously and discards buffered data.

## Configuration
- REQ_SYNC_EN defined: data_req passes through a two-flop synchroniser, reset to 0. This is required when driven from RPi GPIO.
- REQ_SYNC_EN undefined: data_req is used directly as req_s. This is for a synchronous upstream or simulation; latency is 2 cycles shorter as given under Timing.

## Structure
- **Shared package:** pattern_mode encodings, reader FSM state enum, LFSR seed and tap constants.
- **Sub-module pattern_gen:** holds seq, the LFSR, and the lane formation for LANES. It steps on a sample event and outputs the W-bit word.
- **Buffer:** LANES instances of the existing 512x8 dual-port RAM when ADDR_W=9. For other ADDR_W, an inferred W x D memory with a registered read.

## Test plan
Bench values: LANES=3, ADDR_W=4, WRITE_PERIOD=7, REQ_SYNC_EN defined.
- Reset, gen_en=1, mode 0, no data_req:
  - fill_level=16 after sample 16 (cycle 112)
  - sample 17 -> overflow=1, fill_level stays 16
  - ovf_clr pulse -> overflow=0
- After reset, mode 0, four-phase reads -> data_out 24'h020100, 24'h030201, 24'h040302. data_rdy rises 5 edges after the data_req rise.
- Mode 1, first read -> 24'hFDFEFF. Mode 2, first read -> 24'h030001 (lfsr 8'h01). Mode 3 -> fill_level does not change.
- data_req=1 while empty -> data_rdy=0 until the first sample is written, then rises; no spurious word.
- Read commit in the same cycle as a write -> fill_level unchanged. Drain across the pointer wrap 15 -> 0 -> word order continuous.
- rst low while in READY -> data_rdy, data_out, fill_level and overflow all 0 before the next ref_clk edge.
